branch_predictor_bht: RTL and testbench



---
 rtl/branch_predictor_bht_pkg.sv | 15 +
 rtl/branch_predictor_bht_if.sv | 33 +++
 rtl/branch_predictor_bht_sat_counter2.sv | 22 ++
 rtl/branch_predictor_bht.sv | 106 ++++++++++
 tb/tb_branch_predictor_bht.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_bht_pkg.sv
// Shared definitions for the branch history table and its counter helper.
package bht_pkg;

  // 2-bit saturating counter states; MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e        CTR_RESET      = WNT;
  localparam int unsigned BHT_INDEX_BITS = 6;

endpackage

// File: rtl/branch_predictor_bht_if.sv
// Lookup / update / statistics channel of the branch history table.
interface branch_predictor_bht_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STAT_WIDTH = 32
);

  logic                  pred_valid_in;
  logic [ADDR_WIDTH-1:0] pred_pc_in;
  logic                  stall_in;
  logic                  pred_taken_out;
  logic                  upd_valid_in;
  logic [ADDR_WIDTH-1:0] upd_pc_in;
  logic                  upd_taken_in;
  logic                  upd_pred_in;
  logic                  mispredict_out;
  logic [STAT_WIDTH-1:0] branch_count_out;
  logic [STAT_WIDTH-1:0] mispredict_count_out;

  // Pipeline side: issues lookups and resolved outcomes.
  modport master (
    output pred_valid_in, pred_pc_in, stall_in,
    output upd_valid_in, upd_pc_in, upd_taken_in, upd_pred_in,
    input  pred_taken_out, mispredict_out, branch_count_out, mispredict_count_out
  );

  // Predictor side.
  modport slave (
    input  pred_valid_in, pred_pc_in, stall_in,
    input  upd_valid_in, upd_pc_in, upd_taken_in, upd_pred_in,
    output pred_taken_out, mispredict_out, branch_count_out, mispredict_count_out
  );

endinterface

// File: rtl/branch_predictor_bht_sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
module sat_counter2
  import bht_pkg::*;
(
  input  ctr_e cur_i,
  input  logic taken_i,
  output ctr_e next_o
);

  // Step one state toward the outcome, saturating at SNT / ST.
  always_comb begin
    next_o = cur_i;
    unique case (cur_i)
      SNT: next_o = taken_i ? WNT : SNT;
      WNT: next_o = taken_i ? WT  : SNT;
      WT:  next_o = taken_i ? ST  : WNT;
      ST:  next_o = taken_i ? ST  : WT;
      default: next_o = CTR_RESET;
    endcase
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table: IF-stage prediction, ID-stage training,
// registered mispredict flush pulse and saturating branch statistics.
module branch_predictor_bht
  import bht_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INDEX_BITS = BHT_INDEX_BITS,
  parameter int unsigned STAT_WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_predictor_bht_if.slave bht_if
);

  localparam int unsigned NUM_ENTRIES = 1 << INDEX_BITS;

  ctr_e                   ctr_q   [NUM_ENTRIES];
  ctr_e                   ctr_d   [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_q;
  logic [NUM_ENTRIES-1:0] valid_d;

  logic                   pred_taken_q, pred_taken_d;
  logic                   mispredict_q, mispredict_d;
  logic [STAT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
  logic [STAT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;

  logic [INDEX_BITS-1:0]  pred_idx;
  logic [INDEX_BITS-1:0]  upd_idx;
  logic [1:0]             pred_ctr;
  ctr_e                   upd_ctr_cur;
  ctr_e                   upd_ctr_nxt;
  logic                   mispredict_now;
  logic                   unused_pc_bits;

  assign pred_idx = bht_if.pred_pc_in[INDEX_BITS+1:2];
  assign upd_idx  = bht_if.upd_pc_in[INDEX_BITS+1:2];

  // Only the index bits address the table; tags are deliberately absent.
  assign unused_pc_bits = ^{bht_if.pred_pc_in[ADDR_WIDTH-1:INDEX_BITS+2], bht_if.pred_pc_in[1:0],
                            bht_if.upd_pc_in[ADDR_WIDTH-1:INDEX_BITS+2],  bht_if.upd_pc_in[1:0]};

  // Never-trained entries start from the weakly-not-taken state.
  assign upd_ctr_cur    = valid_q[upd_idx] ? ctr_q[upd_idx] : CTR_RESET;
  assign mispredict_now = bht_if.upd_valid_in & (bht_if.upd_taken_in ^ bht_if.upd_pred_in);

  sat_counter2 u_upd_ctr (
    .cur_i   (upd_ctr_cur),
    .taken_i (bht_if.upd_taken_in),
    .next_o  (upd_ctr_nxt)
  );

  // Next-state: lookup reads the pre-update table, so a same-index update is
  // only visible on the following cycle.
  always_comb begin
    ctr_d         = ctr_q;
    valid_d       = valid_q;
    pred_taken_d  = pred_taken_q;
    mispredict_d  = mispredict_now;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    pred_ctr      = ctr_q[pred_idx];

    if (!bht_if.stall_in) begin
      pred_taken_d = bht_if.pred_valid_in & valid_q[pred_idx] & pred_ctr[1];
    end

    if (bht_if.upd_valid_in) begin
      valid_d[upd_idx] = 1'b1;
      ctr_d[upd_idx]   = upd_ctr_nxt;
      if (branch_cnt_q != '1) begin
        branch_cnt_d = branch_cnt_q + STAT_WIDTH'(1);
      end
    end

    if (mispredict_now && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + STAT_WIDTH'(1);
    end
  end

  // State registers with asynchronous clear of the whole table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        ctr_q[i] <= CTR_RESET;
      end
      valid_q       <= '0;
      pred_taken_q  <= 1'b0;
      mispredict_q  <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      ctr_q         <= ctr_d;
      valid_q       <= valid_d;
      pred_taken_q  <= pred_taken_d;
      mispredict_q  <= mispredict_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bht_if.pred_taken_out       = pred_taken_q;
  assign bht_if.mispredict_out       = mispredict_q;
  assign bht_if.branch_count_out     = branch_cnt_q;
  assign bht_if.mispredict_count_out = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht with a scoreboard queue.
module tb_branch_predictor_bht;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  branch_predictor_bht_if #(.ADDR_WIDTH(32), .STAT_WIDTH(32)) bif ();

  branch_predictor_bht #(
    .ADDR_WIDTH (32),
    .INDEX_BITS (6),
    .STAT_WIDTH (32)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bht_if (bif)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  int          m_ctr [64];
  bit          m_valid [64];
  logic        m_pred;
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      0:       return {31'd0, bif.pred_taken_out};
      1:       return {31'd0, bif.mispredict_out};
      2:       return bif.branch_count_out;
      default: return bif.mispredict_count_out;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i]   = 1;
      m_valid[i] = 0;
    end
    m_pred = 0;
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  // One clock of stimulus: drive at negedge, push expectations, then pop and
  // compare once the registered outputs have settled after the rising edge.
  task automatic step(string tag, bit pv, logic [31:0] ppc, bit stall,
                      bit uv, logic [31:0] upc, bit ut, bit up);
    int   pi, ui, c;
    exp_t e;
    @(negedge clk);
    bif.pred_valid_in = pv;
    bif.pred_pc_in    = ppc;
    bif.stall_in      = stall;
    bif.upd_valid_in  = uv;
    bif.upd_pc_in     = upc;
    bif.upd_taken_in  = ut;
    bif.upd_pred_in   = up;

    pi = int'(ppc[7:2]);
    ui = int'(upc[7:2]);
    if (!stall) m_pred = pv && m_valid[pi] && (m_ctr[pi] >= 2);
    if (uv) begin
      c = m_valid[ui] ? m_ctr[ui] : 1;
      c = ut ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
      m_ctr[ui] = c;
      m_valid[ui] = 1;
      if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
      if ((ut != up) && (m_mcnt != 32'hFFFF_FFFF)) m_mcnt++;
    end
    sb.push_back('{{tag, ".pred"}, 0, {31'd0, m_pred}});
    sb.push_back('{{tag, ".misp"}, 1, {31'd0, uv && (ut != up)}});
    sb.push_back('{{tag, ".bcnt"}, 2, m_bcnt});
    sb.push_back('{{tag, ".mcnt"}, 3, m_mcnt});

    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic idle(string tag);
    step(tag, 0, 32'h0, 0, 0, 32'h0, 0, 0);
  endtask

  localparam logic [31:0] PC_A   = 32'h0040_0010;
  localparam logic [31:0] PC_AL  = 32'h0040_0110;
  localparam logic [31:0] PC_B   = 32'h0040_0020;
  localparam logic [31:0] PC_C   = 32'h0040_0000;

  initial begin
    bif.pred_valid_in = 0;
    bif.pred_pc_in    = '0;
    bif.stall_in      = 0;
    bif.upd_valid_in  = 0;
    bif.upd_pc_in     = '0;
    bif.upd_taken_in  = 0;
    bif.upd_pred_in   = 0;
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst.pred", {31'd0, bif.pred_taken_out}, 32'd0);
    check("rst.misp", {31'd0, bif.mispredict_out}, 32'd0);
    check("rst.bcnt", bif.branch_count_out, 32'd0);
    check("rst.mcnt", bif.mispredict_count_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lookup of an untrained entry
    step("lk0", 1, PC_C, 0, 0, 32'h0, 0, 0);

    // Two taken updates, each mispredicted: 01 -> 10 -> 11
    step("upd1", 0, 32'h0, 0, 1, PC_A, 1, 0);
    step("upd2", 0, 32'h0, 0, 1, PC_A, 1, 0);
    step("lkA", 1, PC_A, 0, 0, 32'h0, 0, 0);
    check("lkA.pred_const", {31'd0, bif.pred_taken_out}, 32'd1);
    check("lkA.bcnt_const", bif.branch_count_out, 32'd2);
    check("lkA.mcnt_const", bif.mispredict_count_out, 32'd2);

    // Hysteresis: saturate at ST, then two not-taken outcomes
    for (int i = 0; i < 3; i++) step("hyst_t", 0, 32'h0, 0, 1, PC_A, 1, 1);
    step("hyst_n1", 0, 32'h0, 0, 1, PC_A, 0, 1);
    step("hyst_lk1", 1, PC_A, 0, 0, 32'h0, 0, 0);
    check("hyst_lk1.const", {31'd0, bif.pred_taken_out}, 32'd1);
    step("hyst_n2", 0, 32'h0, 0, 1, PC_A, 0, 1);
    step("hyst_lk2", 1, PC_A, 0, 0, 32'h0, 0, 0);
    check("hyst_lk2.const", {31'd0, bif.pred_taken_out}, 32'd0);

    // Aliasing through shared index bits
    step("alias_t1", 0, 32'h0, 0, 1, PC_A, 1, 0);
    step("alias_t2", 0, 32'h0, 0, 1, PC_A, 1, 1);
    step("alias_lk", 1, PC_AL, 0, 0, 32'h0, 0, 0);
    check("alias.const", {31'd0, bif.pred_taken_out}, 32'd1);

    // Back to WNT, then same-cycle lookup + taken update to index 4
    step("dn1", 0, 32'h0, 0, 1, PC_A, 0, 1);
    step("dn2", 0, 32'h0, 0, 1, PC_A, 0, 1);
    step("same", 1, PC_A, 0, 1, PC_A, 1, 0);
    check("same.const", {31'd0, bif.pred_taken_out}, 32'd0);
    step("same_nx", 1, PC_A, 0, 0, 32'h0, 0, 0);
    check("same_nx.const", {31'd0, bif.pred_taken_out}, 32'd1);

    // Stall holds the prediction even with a lookup that would return 0
    for (int i = 0; i < 3; i++) step("stall", 1, PC_B, 1, 0, 32'h0, 0, 0);
    check("stall.const", {31'd0, bif.pred_taken_out}, 32'd1);
    step("unstall", 1, PC_B, 0, 0, 32'h0, 0, 0);

    // Independent indices in the same cycle; update during stall still trains
    step("indep", 1, PC_A, 0, 1, PC_B, 1, 0);
    step("stall_upd", 1, PC_C, 1, 1, PC_B, 1, 0);
    step("lkB", 1, PC_B, 0, 0, 32'h0, 0, 0);

    // Saturation at SNT
    for (int i = 0; i < 4; i++) step("snt", 0, 32'h0, 0, 1, PC_C, 0, 0);
    step("snt_t", 0, 32'h0, 0, 1, PC_C, 1, 0);
    step("snt_lk", 1, PC_C, 0, 0, 32'h0, 0, 0);
    step("snt_t2", 0, 32'h0, 0, 1, PC_C, 1, 1);
    step("snt_lk2", 1, PC_C, 0, 0, 32'h0, 0, 0);
    idle("idle");

    // Mixed traffic across a few indices, including aliases
    for (int i = 0; i < 40; i++) begin
      logic [31:0] pcs [4];
      pcs[0] = PC_A; pcs[1] = PC_AL; pcs[2] = PC_B; pcs[3] = PC_C;
      step("mix", 1'($urandom_range(0, 1)), pcs[$urandom_range(0, 3)],
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           pcs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Train, then asynchronous reset mid-cycle
    step("pre_rst_t1", 0, 32'h0, 0, 1, PC_A, 1, 0);
    step("pre_rst_t2", 1, PC_A, 0, 1, PC_A, 1, 0);
    step("pre_rst_lk", 1, PC_A, 0, 1, PC_A, 1, 0);
    check("pre_rst.pred_const", {31'd0, bif.pred_taken_out}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.pred", {31'd0, bif.pred_taken_out}, 32'd0);
    check("arst.misp", {31'd0, bif.mispredict_out}, 32'd0);
    check("arst.bcnt", bif.branch_count_out, 32'd0);
    check("arst.mcnt", bif.mispredict_count_out, 32'd0);
    model_reset();
    @(negedge clk);
    bif.pred_valid_in = 0;
    bif.upd_valid_in  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_lk", 1, PC_A, 0, 0, 32'h0, 0, 0);
    check("post_rst.const", {31'd0, bif.pred_taken_out}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound in case the stimulus ever stalls.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed no finish expected finish by 200000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
